// File: rtl/mc_pkg.sv
// Shared encodings for the MIPS-lite multi-cycle control unit:
// opcodes, FSM state numbering, ALUOp codes and the control-word layout.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_NORI  = 6'b001110;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_RWB    = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9,
        ST_NORIEX = 4'd10,
        ST_NORIWB = 4'd11
    } state_e;

    typedef enum logic [2:0] {
        ALUOP_ADD   = 3'b000,
        ALUOP_SUB   = 3'b001,
        ALUOP_FUNCT = 3'b010,
        ALUOP_NOR   = 3'b011
    } aluop_e;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic [1:0] pcsource;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zext;
        aluop_e     aluop;
    } ctrl_t;

endpackage

// File: rtl/mc_control_if.sv
// Control bundle between the main control FSM (slave side) and the datapath
// that supplies the opcode and memory handshake (master side).
interface mc_control_if;
    import mc_pkg::*;

    logic [5:0] op;
    logic       mem_ready;
    logic       pcwrite;
    logic       pcwritecond;
    logic [1:0] pcsource;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zext;
    logic       aluop2;
    logic       aluop1;
    logic       aluop0;
    logic       illegal_op;
    logic       instr_done;

    modport slave (
        input  op, mem_ready,
        output pcwrite, pcwritecond, pcsource, iord, memread, memwrite, irwrite,
               memtoreg, regdst, regwrite, alusrca, alusrcb, zext,
               aluop2, aluop1, aluop0, illegal_op, instr_done
    );

    modport master (
        output op, mem_ready,
        input  pcwrite, pcwritecond, pcsource, iord, memread, memwrite, irwrite,
               memtoreg, regdst, regwrite, alusrca, alusrcb, zext,
               aluop2, aluop1, aluop0, illegal_op, instr_done
    );

endinterface

// File: rtl/mc_outdec.sv
// Pure state-to-control-word decoder. FETCH reports irwrite/pcwrite as 1;
// the parent gates them with the memory handshake.
module mc_outdec
    import mc_pkg::*;
(
    input  state_e state_i,
    output ctrl_t  ctrl_o
);

    // Moore control word for each FSM state; unlisted fields stay 0
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.memread  = 1'b1;
                ctrl_o.irwrite  = 1'b1;
                ctrl_o.pcwrite  = 1'b1;
                ctrl_o.alusrcb  = SRCB_FOUR;
                ctrl_o.aluop    = ALUOP_ADD;
                ctrl_o.pcsource = PCSRC_ALU;
            end
            ST_DECODE: begin
                ctrl_o.alusrcb = SRCB_BRANCH;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            ST_MEMADR: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            ST_MEMRD: begin
                ctrl_o.memread = 1'b1;
                ctrl_o.iord    = 1'b1;
            end
            ST_MEMWB: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.memtoreg = 1'b1;
            end
            ST_MEMWR: begin
                ctrl_o.memwrite = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            ST_EXEC: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_REG;
                ctrl_o.aluop   = ALUOP_FUNCT;
            end
            ST_RWB: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.regdst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_o.alusrca     = 1'b1;
                ctrl_o.alusrcb     = SRCB_REG;
                ctrl_o.aluop       = ALUOP_SUB;
                ctrl_o.pcwritecond = 1'b1;
                ctrl_o.pcsource    = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl_o.pcwrite  = 1'b1;
                ctrl_o.pcsource = PCSRC_JUMP;
            end
            ST_NORIEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
                ctrl_o.zext    = 1'b1;
                ctrl_o.aluop   = ALUOP_NOR;
            end
            ST_NORIWB: begin
                ctrl_o.regwrite = 1'b1;
            end
            default: begin
                ctrl_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle main control FSM: state register, next-state logic and the
// mem_ready / reset gating applied on top of the state decoder.
module mc_control
    import mc_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    mc_control_if.slave bus
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl_s;
    ctrl_t  gated_s;
    ctrl_t  out_s;
    logic   fetch_go_s;
    logic   illegal_s;
    logic   done_s;

    mc_outdec u_outdec (
        .state_i (state_q),
        .ctrl_o  (ctrl_s)
    );

    // State register; reset lands in FETCH immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the op/handshake-dependent illegal and done flags
    always_comb begin
        state_d   = state_q;
        illegal_s = 1'b0;
        done_s    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (bus.mem_ready) state_d = ST_DECODE;
                else               state_d = ST_FETCH;
            end
            ST_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_NORI:      state_d = ST_NORIEX;
                    default: begin
                        illegal_s = 1'b1;
                        done_s    = 1'b1;
                        state_d   = ST_FETCH;
                    end
                endcase
            end
            ST_MEMADR: begin
                if (bus.op == OP_LW) state_d = ST_MEMRD;
                else                 state_d = ST_MEMWR;
            end
            ST_MEMRD: begin
                if (bus.mem_ready) state_d = ST_MEMWB;
                else               state_d = ST_MEMRD;
            end
            ST_MEMWR: begin
                if (bus.mem_ready) begin
                    state_d = ST_FETCH;
                    done_s  = 1'b1;
                end else begin
                    state_d = ST_MEMWR;
                end
            end
            ST_EXEC:   state_d = ST_RWB;
            ST_NORIEX: state_d = ST_NORIWB;
            ST_MEMWB, ST_RWB, ST_BRANCH, ST_JUMP, ST_NORIWB: begin
                state_d = ST_FETCH;
                done_s  = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign fetch_go_s = (state_q != ST_FETCH) | bus.mem_ready;

    // IR/PC load only when the fetch read completes; everything drops in reset
    always_comb begin
        gated_s         = ctrl_s;
        gated_s.irwrite = ctrl_s.irwrite & fetch_go_s;
        gated_s.pcwrite = ctrl_s.pcwrite & fetch_go_s;
        out_s           = rst_n ? gated_s : '0;
    end

    assign bus.pcwrite     = out_s.pcwrite;
    assign bus.pcwritecond = out_s.pcwritecond;
    assign bus.pcsource    = out_s.pcsource;
    assign bus.iord        = out_s.iord;
    assign bus.memread     = out_s.memread;
    assign bus.memwrite    = out_s.memwrite;
    assign bus.irwrite     = out_s.irwrite;
    assign bus.memtoreg    = out_s.memtoreg;
    assign bus.regdst      = out_s.regdst;
    assign bus.regwrite    = out_s.regwrite;
    assign bus.alusrca     = out_s.alusrca;
    assign bus.alusrcb     = out_s.alusrcb;
    assign bus.zext        = out_s.zext;
    assign bus.aluop2      = out_s.aluop[2];
    assign bus.aluop1      = out_s.aluop[1];
    assign bus.aluop0      = out_s.aluop[0];
    assign bus.illegal_op  = rst_n & illegal_s;
    assign bus.instr_done  = rst_n & done_s;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: the driver queues the expected control
// word for every cycle, a negedge monitor pops and compares.
module tb_mc_control;

    logic clk;
    logic rst_n;

    mc_control_if bus ();

    mc_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] NORI = 6'b001110;
    localparam logic [5:0] BAD  = 6'b111111;

    // Bit positions of the observed control vector
    localparam logic [19:0] PCW      = 20'd1 << 19;
    localparam logic [19:0] PCWC     = 20'd1 << 18;
    localparam logic [19:0] PCS_OUT  = 20'd1 << 16;
    localparam logic [19:0] PCS_JMP  = 20'd2 << 16;
    localparam logic [19:0] IORD     = 20'd1 << 15;
    localparam logic [19:0] MRD      = 20'd1 << 14;
    localparam logic [19:0] MWR      = 20'd1 << 13;
    localparam logic [19:0] IRW      = 20'd1 << 12;
    localparam logic [19:0] M2R      = 20'd1 << 11;
    localparam logic [19:0] RDST     = 20'd1 << 10;
    localparam logic [19:0] RWR      = 20'd1 << 9;
    localparam logic [19:0] SRCA     = 20'd1 << 8;
    localparam logic [19:0] SRCB_4   = 20'd1 << 6;
    localparam logic [19:0] SRCB_IMM = 20'd2 << 6;
    localparam logic [19:0] SRCB_SH  = 20'd3 << 6;
    localparam logic [19:0] ZEXT     = 20'd1 << 5;
    localparam logic [19:0] AOP_SUB  = 20'd1 << 2;
    localparam logic [19:0] AOP_FN   = 20'd2 << 2;
    localparam logic [19:0] AOP_NOR  = 20'd3 << 2;
    localparam logic [19:0] ILL      = 20'd1 << 1;
    localparam logic [19:0] DONE     = 20'd1;

    localparam logic [19:0] ZERO     = 20'd0;
    localparam logic [19:0] F_RDY    = PCW | MRD | IRW | SRCB_4;
    localparam logic [19:0] F_STALL  = MRD | SRCB_4;
    localparam logic [19:0] DEC      = SRCB_SH;
    localparam logic [19:0] DEC_ILL  = SRCB_SH | ILL | DONE;
    localparam logic [19:0] MADR     = SRCA | SRCB_IMM;
    localparam logic [19:0] MRD_S    = MRD | IORD;
    localparam logic [19:0] MWB      = RWR | M2R | DONE;
    localparam logic [19:0] MWR_ST   = MWR | IORD;
    localparam logic [19:0] MWR_RDY  = MWR | IORD | DONE;
    localparam logic [19:0] EXEC     = SRCA | AOP_FN;
    localparam logic [19:0] RWB      = RWR | RDST | DONE;
    localparam logic [19:0] BR       = SRCA | AOP_SUB | PCWC | PCS_OUT | DONE;
    localparam logic [19:0] JUMP     = PCW | PCS_JMP | DONE;
    localparam logic [19:0] NEX      = SRCA | SRCB_IMM | ZEXT | AOP_NOR;
    localparam logic [19:0] NWB      = RWR | DONE;

    typedef struct {
        string       nm;
        logic [19:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [19:0] act_s;
    assign act_s = {bus.pcwrite, bus.pcwritecond, bus.pcsource, bus.iord,
                    bus.memread, bus.memwrite, bus.irwrite, bus.memtoreg,
                    bus.regdst, bus.regwrite, bus.alusrca, bus.alusrcb,
                    bus.zext, bus.aluop2, bus.aluop1, bus.aluop0,
                    bus.illegal_op, bus.instr_done};

    // Monitor: compare the observed control vector mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (act_s !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %05h expected %05h", e.nm, act_s, e.v);
            end
        end
    end

    task automatic step(input logic r, input logic [5:0] o, input logic rdy,
                        input logic [19:0] e, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n         = r;
        bus.op        = o;
        bus.mem_ready = rdy;
        x.nm = nm;
        x.v  = e;
        exp_q.push_back(x);
    endtask

    task automatic reset_in_stall();
        exp_t x;
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        x.nm = "rst_async_drop";
        x.v  = ZERO;
        exp_q.push_back(x);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.op        = RT;
        bus.mem_ready = 1'b0;

        step(1'b0, RT, 1'b1, ZERO, "reset0");
        step(1'b0, RT, 1'b1, ZERO, "reset1");

        step(1'b1, RT, 1'b1, F_RDY, "r_fetch");
        step(1'b1, RT, 1'b1, DEC,   "r_decode");
        step(1'b1, RT, 1'b1, EXEC,  "r_exec");
        step(1'b1, RT, 1'b1, RWB,   "r_wb");

        step(1'b1, LW, 1'b1, F_RDY, "lw_fetch");
        step(1'b1, LW, 1'b1, DEC,   "lw_decode");
        step(1'b1, LW, 1'b1, MADR,  "lw_memadr");
        step(1'b1, LW, 1'b0, MRD_S, "lw_memrd_stall0");
        step(1'b1, LW, 1'b0, MRD_S, "lw_memrd_stall1");
        step(1'b1, LW, 1'b0, MRD_S, "lw_memrd_stall2");
        step(1'b1, LW, 1'b1, MRD_S, "lw_memrd_done");
        step(1'b1, LW, 1'b1, MWB,   "lw_memwb");

        step(1'b1, SW, 1'b1, F_RDY,   "sw_fetch");
        step(1'b1, SW, 1'b1, DEC,     "sw_decode");
        step(1'b1, SW, 1'b1, MADR,    "sw_memadr");
        step(1'b1, SW, 1'b1, MWR_RDY, "sw_memwr");

        step(1'b1, BEQ, 1'b1, F_RDY, "beq_fetch");
        step(1'b1, BEQ, 1'b1, DEC,   "beq_decode");
        step(1'b1, BEQ, 1'b1, BR,    "beq_branch");

        step(1'b1, JMP, 1'b1, F_RDY, "j_fetch");
        step(1'b1, JMP, 1'b1, DEC,   "j_decode");
        step(1'b1, JMP, 1'b1, JUMP,  "j_jump");

        step(1'b1, NORI, 1'b1, F_RDY, "nori_fetch");
        step(1'b1, NORI, 1'b1, DEC,   "nori_decode");
        step(1'b1, NORI, 1'b1, NEX,   "nori_ex");
        step(1'b1, NORI, 1'b1, NWB,   "nori_wb");

        step(1'b1, BAD, 1'b0, F_STALL, "ill_fetch_stall");
        step(1'b1, BAD, 1'b1, F_RDY,   "ill_fetch");
        step(1'b1, BAD, 1'b1, DEC_ILL, "ill_decode");

        step(1'b1, SW, 1'b1, F_RDY,  "sw2_fetch");
        step(1'b1, SW, 1'b1, DEC,    "sw2_decode");
        step(1'b1, SW, 1'b1, MADR,   "sw2_memadr");
        step(1'b1, SW, 1'b0, MWR_ST, "sw2_memwr_stall");
        reset_in_stall();
        step(1'b0, SW, 1'b1, ZERO,   "rst_hold");
        step(1'b1, RT, 1'b1, F_RDY,  "post_rst_fetch");
        step(1'b1, RT, 1'b1, DEC,    "post_rst_decode");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
